// File: rtl/rs_issue_select_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_select_pkg
// Purpose  : Shared types and constants for the reservation-station issue
//            stage. issue_t is the payload handed to each ALU port and is
//            meant to be reused by the ALU side.
// Contents : ISSUE_W      - number of ALU issue ports (fixed at 4)
//            DEF_*        - default widths used by the issue payload
//            uop_t        - decoded micro-op carried through issue
//            issue_t      - per-port issue payload {op, dst_tag, v1, v2}
//            popcnt4()    - population count of a 4-bit vector
// Revision : 1.0 - initial release
// ============================================================================
package rs_issue_select_pkg;

   localparam int ISSUE_W      = 4;
   localparam int UOP_W        = 16;
   localparam int DEF_RS_DEPTH = 16;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_TAG_W    = 6;

   // Decoded micro-op as stored in the reservation station.
   typedef logic [UOP_W-1:0] uop_t;

   // Payload latched into each ALU issue register.
   typedef struct packed {
      uop_t                  op;
      logic [DEF_TAG_W-1:0]  dst_tag;
      logic [DEF_DATA_W-1:0] v1;
      logic [DEF_DATA_W-1:0] v2;
   } issue_t;

   function automatic logic [2:0] popcnt4(input logic [ISSUE_W-1:0] v);
      logic [2:0] n;
      n = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         n = n + {2'b00, v[k]};
      end
      return n;
   endfunction

endpackage : rs_issue_select_pkg
`default_nettype wire

// File: rtl/rs_issue_select_age_matrix.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_select_age_matrix
// Purpose  : Allocation-age tracking for the reservation station. Keeps an
//            RS_DEPTH x RS_DEPTH matrix where r_older[i][j]=1 means entry i
//            was allocated before entry j, and reports, for every entry, how
//            many currently ready entries are older than it.
// Ports    : clk, rst_n     - clock, asynchronous active-low reset
//            flush_i        - suppresses age updates for the cycle
//            entry_wen      - RS allocation strobes
//            ready_mask     - entries eligible for issue this cycle
//            rank_o         - per-entry count of older ready entries
// Revision : 1.0 - initial release
// ============================================================================
module rs_issue_select_age_matrix #(
   parameter int RS_DEPTH = 16,
   parameter int RANK_W   = $clog2(RS_DEPTH) + 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              flush_i,
   input  logic [RS_DEPTH-1:0]               entry_wen,
   input  logic [RS_DEPTH-1:0]               ready_mask,
   output logic [RS_DEPTH-1:0][RANK_W-1:0]   rank_o
);

   logic [RS_DEPTH-1:0][RS_DEPTH-1:0] r_older;
   logic [RS_DEPTH-1:0][RS_DEPTH-1:0] w_older_nxt;

   // A newly written entry becomes younger than everything present. When
   // several entries are written together, the lower index counts as older.
   // Rows of free entries may hold stale bits; they never matter because only
   // ready entries contribute to a rank.
   always_comb begin
      w_older_nxt = r_older;
      for (int i = 0; i < RS_DEPTH; i++) begin
         for (int j = 0; j < RS_DEPTH; j++) begin
            if (i == j) begin
               w_older_nxt[i][j] = 1'b0;
            end else if (entry_wen[i] && entry_wen[j]) begin
               w_older_nxt[i][j] = 1'(i < j);
            end else if (entry_wen[i]) begin
               w_older_nxt[i][j] = 1'b0;
            end else if (entry_wen[j]) begin
               w_older_nxt[i][j] = 1'b1;
            end
         end
      end
   end

   // Flushed cycles leave the matrix untouched: the RS drops every busy
   // entry, so any allocation racing the flush is discarded anyway.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_older <= '0;
      end else if (!flush_i) begin
         r_older <= w_older_nxt;
      end
   end

   always_comb begin
      rank_o = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         for (int j = 0; j < RS_DEPTH; j++) begin
            if (j != i) begin
               rank_o[i] = rank_o[i] + RANK_W'(ready_mask[j] & r_older[j][i]);
            end
         end
      end
   end

endmodule : rs_issue_select_age_matrix
`default_nettype wire

// File: rtl/rs_issue_select.sv
`default_nettype none
// ============================================================================
// Module   : rs_issue_select
// Purpose  : Issue selection for the reservation station. Picks up to four of
//            the oldest ready entries per cycle, maps them onto the available
//            ALU ports in ascending port order, returns the grant vector and
//            read indices to the RS, and latches the RS read data into one
//            issue register per ALU with valid/ready backpressure.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            flush_i             - pipeline flush (kills grants and issue regs)
//            entry_wen           - RS allocation strobes (feed the age matrix)
//            ready_mask          - RS entries ready to issue
//            issue_grant         - per-entry grant back to the RS
//            sel_idx_k           - RS read index for port k
//            rs_*_k              - RS read data at sel_idx_k
//            fu_valid_k/ready_k  - issue register k handshake with ALU k
//            fu_*_k              - issue register k payload
// Revision : 1.0 - initial release
// ============================================================================
module rs_issue_select
   import rs_issue_select_pkg::*;
#(
   parameter int RS_DEPTH = DEF_RS_DEPTH,
   parameter int RS_IDX_W = $clog2(RS_DEPTH),
   parameter int DATA_W   = DEF_DATA_W,
   parameter int TAG_W    = DEF_TAG_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush_i,
   input  logic [RS_DEPTH-1:0] entry_wen,
   input  logic [RS_DEPTH-1:0] ready_mask,
   output logic [RS_DEPTH-1:0] issue_grant,

   output logic [RS_IDX_W-1:0] sel_idx_0,
   output logic [RS_IDX_W-1:0] sel_idx_1,
   output logic [RS_IDX_W-1:0] sel_idx_2,
   output logic [RS_IDX_W-1:0] sel_idx_3,

   input  uop_t                rs_op_0,
   input  logic [TAG_W-1:0]    rs_dst_tag_0,
   input  logic [DATA_W-1:0]   rs_v1_0,
   input  logic [DATA_W-1:0]   rs_v2_0,
   input  uop_t                rs_op_1,
   input  logic [TAG_W-1:0]    rs_dst_tag_1,
   input  logic [DATA_W-1:0]   rs_v1_1,
   input  logic [DATA_W-1:0]   rs_v2_1,
   input  uop_t                rs_op_2,
   input  logic [TAG_W-1:0]    rs_dst_tag_2,
   input  logic [DATA_W-1:0]   rs_v1_2,
   input  logic [DATA_W-1:0]   rs_v2_2,
   input  uop_t                rs_op_3,
   input  logic [TAG_W-1:0]    rs_dst_tag_3,
   input  logic [DATA_W-1:0]   rs_v1_3,
   input  logic [DATA_W-1:0]   rs_v2_3,

   output logic                fu_valid_0,
   input  logic                fu_ready_0,
   output uop_t                fu_op_0,
   output logic [TAG_W-1:0]    fu_dst_tag_0,
   output logic [DATA_W-1:0]   fu_v1_0,
   output logic [DATA_W-1:0]   fu_v2_0,
   output logic                fu_valid_1,
   input  logic                fu_ready_1,
   output uop_t                fu_op_1,
   output logic [TAG_W-1:0]    fu_dst_tag_1,
   output logic [DATA_W-1:0]   fu_v1_1,
   output logic [DATA_W-1:0]   fu_v2_1,
   output logic                fu_valid_2,
   input  logic                fu_ready_2,
   output uop_t                fu_op_2,
   output logic [TAG_W-1:0]    fu_dst_tag_2,
   output logic [DATA_W-1:0]   fu_v1_2,
   output logic [DATA_W-1:0]   fu_v2_2,
   output logic                fu_valid_3,
   input  logic                fu_ready_3,
   output uop_t                fu_op_3,
   output logic [TAG_W-1:0]    fu_dst_tag_3,
   output logic [DATA_W-1:0]   fu_v1_3,
   output logic [DATA_W-1:0]   fu_v2_3
);

   localparam int RANK_W = RS_IDX_W + 1;

   logic [RS_DEPTH-1:0][RANK_W-1:0] w_rank;
   logic [RS_DEPTH-1:0]             w_ready;
   logic [RS_DEPTH-1:0]             w_sel;
   logic [ISSUE_W-1:0]              w_fu_ready;
   logic [ISSUE_W-1:0]              w_avail;
   logic [ISSUE_W-1:0]              w_hit;
   logic [RANK_W-1:0]               w_n_av;
   logic [RANK_W-1:0]               w_port_slot [ISSUE_W];
   logic [ISSUE_W-1:0][RS_IDX_W-1:0] w_sel_idx;
   issue_t                          w_rs [ISSUE_W];

   logic [ISSUE_W-1:0]              r_fu_valid;
   issue_t                          r_fu [ISSUE_W];

   // ---------------------------------------------------------------------
   // Port-level bundling
   // ---------------------------------------------------------------------
   assign w_fu_ready = {fu_ready_3, fu_ready_2, fu_ready_1, fu_ready_0};

   assign w_rs[0] = {rs_op_0, rs_dst_tag_0, rs_v1_0, rs_v2_0};
   assign w_rs[1] = {rs_op_1, rs_dst_tag_1, rs_v1_1, rs_v2_1};
   assign w_rs[2] = {rs_op_2, rs_dst_tag_2, rs_v1_2, rs_v2_2};
   assign w_rs[3] = {rs_op_3, rs_dst_tag_3, rs_v1_3, rs_v2_3};

   // ---------------------------------------------------------------------
   // Age tracking
   // ---------------------------------------------------------------------
   rs_issue_select_age_matrix #(
      .RS_DEPTH (RS_DEPTH),
      .RANK_W   (RANK_W)
   ) u_age_matrix (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush_i    (flush_i),
      .entry_wen  (entry_wen),
      .ready_mask (ready_mask),
      .rank_o     (w_rank)
   );

   // ---------------------------------------------------------------------
   // Selection and port mapping
   // ---------------------------------------------------------------------
   // A port can take a new uop if it is empty or its current uop leaves now.
   assign w_avail = ~r_fu_valid | w_fu_ready;
   assign w_ready = flush_i ? '0 : ready_mask;

   // w_port_slot[k] is the ordinal of port k among the available ports, so
   // the rank-r entry lands on the r-th available port.
   always_comb begin
      w_n_av = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         w_port_slot[k] = w_n_av;
         w_n_av         = w_n_av + RANK_W'(w_avail[k]);
      end
   end

   always_comb begin
      w_sel = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         w_sel[i] = w_ready[i] && (w_rank[i] < w_n_av);
      end
   end

   always_comb begin
      w_hit     = '0;
      w_sel_idx = '0;
      for (int k = 0; k < ISSUE_W; k++) begin
         if (w_avail[k]) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
               if (w_sel[e] && (w_rank[e] == w_port_slot[k])) begin
                  w_hit[k]     = 1'b1;
                  w_sel_idx[k] = RS_IDX_W'(e);
               end
            end
         end
      end
   end

   assign issue_grant = w_sel;
   assign sel_idx_0   = w_sel_idx[0];
   assign sel_idx_1   = w_sel_idx[1];
   assign sel_idx_2   = w_sel_idx[2];
   assign sel_idx_3   = w_sel_idx[3];

   // ---------------------------------------------------------------------
   // Issue registers
   // ---------------------------------------------------------------------
   // A held uop (valid and not ready) is never available, so its payload is
   // only ever rewritten when the port is free or draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fu_valid <= '0;
         for (int k = 0; k < ISSUE_W; k++) begin
            r_fu[k] <= '0;
         end
      end else if (flush_i) begin
         r_fu_valid <= '0;
      end else begin
         for (int k = 0; k < ISSUE_W; k++) begin
            if (w_hit[k]) begin
               r_fu[k]       <= w_rs[k];
               r_fu_valid[k] <= 1'b1;
            end else if (w_avail[k]) begin
               r_fu_valid[k] <= 1'b0;
            end
         end
      end
   end

   assign fu_valid_0   = r_fu_valid[0];
   assign fu_op_0      = r_fu[0].op;
   assign fu_dst_tag_0 = r_fu[0].dst_tag;
   assign fu_v1_0      = r_fu[0].v1;
   assign fu_v2_0      = r_fu[0].v2;

   assign fu_valid_1   = r_fu_valid[1];
   assign fu_op_1      = r_fu[1].op;
   assign fu_dst_tag_1 = r_fu[1].dst_tag;
   assign fu_v1_1      = r_fu[1].v1;
   assign fu_v2_1      = r_fu[1].v2;

   assign fu_valid_2   = r_fu_valid[2];
   assign fu_op_2      = r_fu[2].op;
   assign fu_dst_tag_2 = r_fu[2].dst_tag;
   assign fu_v1_2      = r_fu[2].v1;
   assign fu_v2_2      = r_fu[2].v2;

   assign fu_valid_3   = r_fu_valid[3];
   assign fu_op_3      = r_fu[3].op;
   assign fu_dst_tag_3 = r_fu[3].dst_tag;
   assign fu_v1_3      = r_fu[3].v1;
   assign fu_v2_3      = r_fu[3].v2;

endmodule : rs_issue_select
`default_nettype wire

// File: tb/tb_rs_issue_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_issue_select
// Purpose  : Directed self-checking bench for rs_issue_select. A small RS
//            read-port model returns entry-specific payloads; stimulus pushes
//            the payload each port is expected to deliver, and a monitor pops
//            and compares whenever an ALU port completes a handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_issue_select;
   import rs_issue_select_pkg::*;

   typedef logic [85:0] pay_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush_i = 1'b0;
   logic [15:0] entry_wen = '0;
   logic [15:0] rdy = '0;
   logic [3:0]  fr = '0;
   logic [15:0] issue_grant;
   logic [3:0]  sel_idx_0, sel_idx_1, sel_idx_2, sel_idx_3;
   uop_t        rs_op_0, rs_op_1, rs_op_2, rs_op_3;
   logic [5:0]  rs_dst_tag_0, rs_dst_tag_1, rs_dst_tag_2, rs_dst_tag_3;
   logic [31:0] rs_v1_0, rs_v1_1, rs_v1_2, rs_v1_3;
   logic [31:0] rs_v2_0, rs_v2_1, rs_v2_2, rs_v2_3;
   logic        fu_valid_0, fu_valid_1, fu_valid_2, fu_valid_3;
   uop_t        fu_op_0, fu_op_1, fu_op_2, fu_op_3;
   logic [5:0]  fu_dst_tag_0, fu_dst_tag_1, fu_dst_tag_2, fu_dst_tag_3;
   logic [31:0] fu_v1_0, fu_v1_1, fu_v1_2, fu_v1_3;
   logic [31:0] fu_v2_0, fu_v2_1, fu_v2_2, fu_v2_3;

   int   total = 0;
   int   bad   = 0;
   pay_t expq [4][$];

   always #5 clk = ~clk;

   // RS read data model: every entry carries a payload derived from its index.
   function automatic uop_t op_of(input logic [3:0] e);
      return 16'hA000 | {12'h000, e};
   endfunction
   function automatic logic [5:0] tag_of(input logic [3:0] e);
      return {2'b10, e};
   endfunction
   function automatic logic [31:0] v1_of(input logic [3:0] e);
      return 32'h1000_0000 | {28'h0, e};
   endfunction
   function automatic logic [31:0] v2_of(input logic [3:0] e);
      return 32'h2000_0000 | {24'h0, e, 4'h5};
   endfunction
   function automatic pay_t exp_of(input logic [3:0] e);
      return {op_of(e), tag_of(e), v1_of(e), v2_of(e)};
   endfunction

   assign rs_op_0 = op_of(sel_idx_0);  assign rs_dst_tag_0 = tag_of(sel_idx_0);
   assign rs_v1_0 = v1_of(sel_idx_0);  assign rs_v2_0      = v2_of(sel_idx_0);
   assign rs_op_1 = op_of(sel_idx_1);  assign rs_dst_tag_1 = tag_of(sel_idx_1);
   assign rs_v1_1 = v1_of(sel_idx_1);  assign rs_v2_1      = v2_of(sel_idx_1);
   assign rs_op_2 = op_of(sel_idx_2);  assign rs_dst_tag_2 = tag_of(sel_idx_2);
   assign rs_v1_2 = v1_of(sel_idx_2);  assign rs_v2_2      = v2_of(sel_idx_2);
   assign rs_op_3 = op_of(sel_idx_3);  assign rs_dst_tag_3 = tag_of(sel_idx_3);
   assign rs_v1_3 = v1_of(sel_idx_3);  assign rs_v2_3      = v2_of(sel_idx_3);

   wire [3:0] fuv = {fu_valid_3, fu_valid_2, fu_valid_1, fu_valid_0};
   pay_t act_pay [4];
   assign act_pay[0] = {fu_op_0, fu_dst_tag_0, fu_v1_0, fu_v2_0};
   assign act_pay[1] = {fu_op_1, fu_dst_tag_1, fu_v1_1, fu_v2_1};
   assign act_pay[2] = {fu_op_2, fu_dst_tag_2, fu_v1_2, fu_v2_2};
   assign act_pay[3] = {fu_op_3, fu_dst_tag_3, fu_v1_3, fu_v2_3};

   rs_issue_select dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
      .entry_wen(entry_wen), .ready_mask(rdy), .issue_grant(issue_grant),
      .sel_idx_0(sel_idx_0), .sel_idx_1(sel_idx_1),
      .sel_idx_2(sel_idx_2), .sel_idx_3(sel_idx_3),
      .rs_op_0(rs_op_0), .rs_dst_tag_0(rs_dst_tag_0), .rs_v1_0(rs_v1_0), .rs_v2_0(rs_v2_0),
      .rs_op_1(rs_op_1), .rs_dst_tag_1(rs_dst_tag_1), .rs_v1_1(rs_v1_1), .rs_v2_1(rs_v2_1),
      .rs_op_2(rs_op_2), .rs_dst_tag_2(rs_dst_tag_2), .rs_v1_2(rs_v1_2), .rs_v2_2(rs_v2_2),
      .rs_op_3(rs_op_3), .rs_dst_tag_3(rs_dst_tag_3), .rs_v1_3(rs_v1_3), .rs_v2_3(rs_v2_3),
      .fu_valid_0(fu_valid_0), .fu_ready_0(fr[0]), .fu_op_0(fu_op_0),
      .fu_dst_tag_0(fu_dst_tag_0), .fu_v1_0(fu_v1_0), .fu_v2_0(fu_v2_0),
      .fu_valid_1(fu_valid_1), .fu_ready_1(fr[1]), .fu_op_1(fu_op_1),
      .fu_dst_tag_1(fu_dst_tag_1), .fu_v1_1(fu_v1_1), .fu_v2_1(fu_v2_1),
      .fu_valid_2(fu_valid_2), .fu_ready_2(fr[2]), .fu_op_2(fu_op_2),
      .fu_dst_tag_2(fu_dst_tag_2), .fu_v1_2(fu_v1_2), .fu_v2_2(fu_v2_2),
      .fu_valid_3(fu_valid_3), .fu_ready_3(fr[3]), .fu_op_3(fu_op_3),
      .fu_dst_tag_3(fu_dst_tag_3), .fu_v1_3(fu_v1_3), .fu_v2_3(fu_v2_3)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: an ALU handshake retires the head of that port's queue.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 4; k++) begin
            if (fuv[k] && fr[k]) begin : g_pop
               pay_t e;
               if (expq[k].size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_issue port%0d: got %0h expected none", k, act_pay[k]);
               end else begin
                  e = expq[k].pop_front();
                  chk($sformatf("port%0d_payload", k), 128'(act_pay[k]), 128'(e));
               end
            end
         end
      end
   end

   // One clock: the RS frees whatever it was granted before the edge.
   task automatic tick();
      logic [15:0] g;
      g = issue_grant;
      @(posedge clk);
      #1;
      rdy       = rdy & ~g;
      entry_wen = '0;
   endtask

   task automatic expect_sel(input string nm, input logic [15:0] g,
                             input logic [3:0] s0, input logic [3:0] s1,
                             input logic [3:0] s2, input logic [3:0] s3);
      chk({nm, "_grant"}, 128'(issue_grant), 128'(g));
      chk({nm, "_sel0"},  128'(sel_idx_0),   128'(s0));
      chk({nm, "_sel1"},  128'(sel_idx_1),   128'(s1));
      chk({nm, "_sel2"},  128'(sel_idx_2),   128'(s2));
      chk({nm, "_sel3"},  128'(sel_idx_3),   128'(s3));
   endtask

   task automatic push(input int k, input logic [3:0] e);
      expq[k].push_back(exp_of(e));
   endtask

   task automatic chk_hold1(input string nm);
      chk({nm, "_op1"}, 128'(fu_op_1), 128'(op_of(4'd11)));
      chk({nm, "_v1_1"}, 128'(fu_v1_1), 128'(v1_of(4'd11)));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_fu_valid", 128'(fuv), 128'(4'b0000));
      chk("reset_grant", 128'(issue_grant), 128'(16'h0000));
      chk("reset_payload", 128'(fu_v1_0), 128'(32'h0));
      rst_n = 1'b1;

      // Three single allocations, all ready with every port free.
      entry_wen = 16'h0008; tick();
      entry_wen = 16'h0080; tick();
      entry_wen = 16'h0002; tick();
      rdy = 16'h008A; fr = 4'hF; #1;
      expect_sel("t1", 16'h008A, 4'd3, 4'd7, 4'd1, 4'd0);
      push(0, 4'd3); push(1, 4'd7); push(2, 4'd1);
      tick();
      chk("t1_fu_valid", 128'(fuv), 128'(4'b0111));
      #1;
      chk("t1_grant_after", 128'(issue_grant), 128'(16'h0000));
      tick();

      // Fill all ports, then simultaneous writes 5 and 2 with only port2 free.
      entry_wen = 16'h3C00; tick();
      rdy = rdy | 16'h3C00; entry_wen = 16'h0024; #1;
      expect_sel("t2_fill", 16'h3C00, 4'd10, 4'd11, 4'd12, 4'd13);
      push(0, 4'd10); push(1, 4'd11); push(2, 4'd12); push(3, 4'd13);
      tick();
      chk("t2_fu_valid", 128'(fuv), 128'(4'b1111));
      rdy = rdy | 16'h0024; fr = 4'b0100; #1;
      expect_sel("t2_one_port", 16'h0004, 4'd0, 4'd0, 4'd2, 4'd0);
      push(2, 4'd2);
      tick();
      fr = 4'b0001; #1;
      expect_sel("t2_next", 16'h0020, 4'd5, 4'd0, 4'd0, 4'd0);
      push(0, 4'd5);
      tick();

      // Port1 holds entry 11 for three cycles while others drain and refill.
      fr = 4'b1101; entry_wen = 16'h0010; tick();
      chk("hold_c1_valid", 128'(fuv), 128'(4'b0010));
      chk_hold1("hold_c1");
      rdy = rdy | 16'h0010; #1;
      expect_sel("hold_c2", 16'h0010, 4'd4, 4'd0, 4'd0, 4'd0);
      push(0, 4'd4);
      tick();
      chk("hold_c2_valid", 128'(fuv), 128'(4'b0011));
      chk_hold1("hold_c2");
      tick();
      chk("hold_c3_valid", 128'(fuv), 128'(4'b0010));
      chk_hold1("hold_c3");
      fr = 4'hF; tick();
      chk("hold_release_valid", 128'(fuv), 128'(4'b0000));

      // Six ready entries: four oldest first, remaining two next cycle.
      entry_wen = 16'h0200; tick();
      entry_wen = 16'h0001; tick();
      entry_wen = 16'h4040; tick();
      entry_wen = 16'h0100; tick();
      entry_wen = 16'h8000; tick();
      rdy = rdy | 16'hC341; #1;
      expect_sel("six_a", 16'h4241, 4'd9, 4'd0, 4'd6, 4'd14);
      push(0, 4'd9); push(1, 4'd0); push(2, 4'd6); push(3, 4'd14);
      tick(); #1;
      expect_sel("six_b", 16'h8100, 4'd8, 4'd15, 4'd0, 4'd0);
      push(0, 4'd8); push(1, 4'd15);
      tick();
      tick();

      // Flush with two held issue registers and four ready entries.
      entry_wen = 16'h3000; tick();
      rdy = rdy | 16'h3000; #1;
      expect_sel("fl_fill", 16'h3000, 4'd12, 4'd13, 4'd0, 4'd0);
      push(0, 4'd12); push(1, 4'd13);
      tick();
      chk("fl_pre_valid", 128'(fuv), 128'(4'b0011));
      fr = 4'b0000; entry_wen = 16'h001E; tick();
      rdy = rdy | 16'h001E; flush_i = 1'b1; #1;
      chk("fl_grant", 128'(issue_grant), 128'(16'h0000));
      tick();
      flush_i = 1'b0; rdy = '0;
      expq[0].delete(); expq[1].delete();
      chk("fl_post_valid", 128'(fuv), 128'(4'b0000));

      // Asynchronous reset while all four ports hold uops.
      fr = 4'hF; entry_wen = 16'h000F; tick();
      rdy = rdy | 16'h000F; #1;
      expect_sel("rst_fill", 16'h000F, 4'd0, 4'd1, 4'd2, 4'd3);
      push(0, 4'd0); push(1, 4'd1); push(2, 4'd2); push(3, 4'd3);
      tick();
      chk("rst_pre_valid", 128'(fuv), 128'(4'b1111));
      fr = 4'b0000; #2;
      rst_n = 1'b0; #1;
      chk("rst_async_valid", 128'(fuv), 128'(4'b0000));
      for (int k = 0; k < 4; k++) expq[k].delete();
      rdy = '0;
      @(negedge clk);
      rst_n = 1'b1;
      entry_wen = 16'h0080; tick();
      entry_wen = 16'h0020; tick();
      rdy = 16'h00A0; fr = 4'hF; #1;
      expect_sel("post_rst", 16'h00A0, 4'd7, 4'd5, 4'd0, 4'd0);
      push(0, 4'd7); push(1, 4'd5);
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain_q%0d", k), 128'(expq[k].size()), 128'(0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rs_issue_select
`default_nettype wire

// File: doc/rs_issue_select.md
Name: rs_issue_select

Overview:
- Issue-side counterpart of the reservation station: consumes its `ready_mask`/`busy_vector`, picks up to 4 oldest ready entries per cycle and returns `issue_grant` plus the four `sel_idx` read indices.
- Latches the RS read data into a per-ALU issue register with valid/ready backpressure toward ALU0..3.
- Tracks allocation age with an RS_DEPTH×RS_DEPTH age matrix fed by the RS write enables.

Parameters:
- RS_DEPTH, Cfg.RS_DEPTH (16), number of RS entries.
- RS_IDX_W, $clog2(RS_DEPTH), entry index width.
- DATA_W, Cfg.ILEN (32), operand width.
- TAG_W, 6, destination tag width.
- ISSUE_W, 4 (fixed), number of ALU ports.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  pipeline flush.
- entry_wen  in  RS_DEPTH  RS allocation strobes (same signal the RS sees).
- ready_mask  in  RS_DEPTH  RS entries busy with both operands ready.
- issue_grant  out  RS_DEPTH  one-hot-per-entry grant back to the RS; the RS frees the entry next edge.
- sel_idx_k (k=0..3)  out  RS_IDX_W  RS read index for port k.
- rs_op_k  in  decode_pkg::uop_t  RS read data for sel_idx_k.
- rs_dst_tag_k  in  TAG_W  RS read data for sel_idx_k.
- rs_v1_k, rs_v2_k  in  DATA_W  RS read data for sel_idx_k.
- fu_valid_k  out  1  issue register k holds a uop.
- fu_ready_k  in  1  ALU k accepts this cycle.
- fu_op_k  out  decode_pkg::uop_t  issue register k contents.
- fu_dst_tag_k  out  TAG_W  issue register k contents.
- fu_v1_k, fu_v2_k  out  DATA_W  issue register k contents.

Behaviour:
- Reset (async): age matrix all 0; fu_valid_k=0; fu payload registers 0.
- issue_grant is combinational and is 0 whenever ready_mask=0.
- Age matrix older[i][j]=1 means entry i is older than entry j. On entry_wen[i] at the edge:
  - column i is set to 1 for every j≠i (all existing entries are older);
  - row i is cleared;
  - for simultaneous writes i<j: older[i][j]=1, older[j][i]=0 (lower index is older).
  - Stale rows of free entries are harmless because only ready entries are compared.
- Port availability: avail_k = !fu_valid_k || fu_ready_k. N_av = popcount(avail).
- Rank of ready entry i = popcount over ready j of older[j][i]. Entry i is selected iff ready and rank < N_av.
- The rank-r selected entry maps to the r-th available port in ascending port order.
- For each port k receiving entry e: sel_idx_k=e and issue_grant[e]=1. Unused ports drive sel_idx_k=0.
- Ports receiving an entry load rs_* into the fu register at the edge and set fu_valid_k=1, a single-cycle grant-to-ALU latency.
- Available ports with no selection clear fu_valid_k if fu_ready_k consumed the held uop.
- Held uop (fu_valid_k && !fu_ready_k): payload must stay stable; port receives nothing.
- At most one grant per entry and at most 4 grants per cycle; an entry is never granted twice because the RS clears busy on grant.
- flush_i has priority:
  - issue_grant=0 combinationally that cycle;
  - all fu_valid_k cleared at the edge;
  - age updates that cycle are ignored, since the RS clears busy.
- Simultaneous entry_wen[i] and a ready entry i cannot occur: the RS only writes non-busy entries.
- Reset mid-operation drops all held uops.

Decomposition:
- Put ISSUE_W and an issue payload struct (op, dst_tag, v1, v2) in a shared package so that issue_pkg::issue_t is reused by the ALUs.
- One sub-module, age_matrix: age update logic plus per-entry rank output; the selection/port mapping and issue registers stay in the top.

Test Plan:
- Write entries 3, then 7, then 1 in successive cycles. All become ready, all ports available → grant=0x008A; port0 gets 3, port1 gets 7, port2 gets 1, port3 invalid. fu_valid=4'b0111 the next cycle.
- Write entries 5 and 2 in the same cycle, both ready, only port2 available (others hold with fu_ready=0) → only entry 2 granted (lower index older) on sel_idx_2=2; entry 5 granted the following cycle when a port frees.
- Six ready entries, all ports free → exactly the 4 oldest are granted; the remaining 2 are granted the next cycle in age order.
- Port1 holds a uop with fu_ready_1=0 for 3 cycles → fu_op_1/fu_v1_1 are stable and no grant maps to port1; on fu_ready_1=1 with no new ready entry → fu_valid_1=0 the next cycle.
- flush_i asserted with 4 ready entries and 2 valid issue registers → issue_grant=0 that cycle; all fu_valid=0 the next cycle.
- Assert rst_n=0 while fu_valid=4'b1111 → all fu_valid=0 immediately (asynchronously); after release, the first writes order correctly from a clean age matrix.
